// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps a note ROM and emits DDS phase increments
// Each ROM word gives duration, octave, semitone and a rest flag; notes end with a silent gap.
module melody_sequencer #(
    parameter int CLOCKS_PER_16TH = 6_250_000,
    parameter int MELODY_LENGTH   = 82,
    parameter int GAP_CYCLES      = 250_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_loop,
    output logic [6:0]  o_rom_addr,
    input  logic [11:0] i_rom_data,
    output logic [31:0] o_phase_inc,
    output logic        o_gate,
    output logic        o_playing,
    output logic        o_melody_end,
    output logic [6:0]  o_note_index
);
    localparam int CW = $clog2(16 * CLOCKS_PER_16TH + 1);
    localparam logic [6:0] LAST_INDEX = 7'(MELODY_LENGTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;

    state_t        r_state;
    logic          r_enable_q;
    logic [CW-1:0] r_count;
    logic [31:0]   r_inc;
    logic          r_tone;

    logic [3:0]    w_semi;
    logic [2:0]    w_oct;
    logic [4:0]    w_dur;
    logic          w_rest;
    logic [31:0]   w_base;
    logic [31:0]   w_inc;
    logic [CW-1:0] w_load;
    logic [CW-1:0] w_count_dec;
    logic [CW-1:0] w_gap;

    assign w_semi      = i_rom_data[3:0];
    assign w_oct       = i_rom_data[6:4];
    assign w_dur       = (i_rom_data[11:8] == 4'd0) ? 5'd16 : {1'b0, i_rom_data[11:8]};
    assign w_rest      = i_rom_data[7] | (w_semi >= 4'd12);
    assign w_load      = CW'(w_dur) * CW'(CLOCKS_PER_16TH) - CW'(1);
    assign w_count_dec = r_count - CW'(1);
    assign w_gap       = CW'(GAP_CYCLES);

    // Octave-7 increments at 50 MHz; lower octaves are reached by right shifts.
    always_comb begin
        w_base = 32'd0;
        case (w_semi)
            4'd0:    w_base = 32'd179788;
            4'd1:    w_base = 32'd190478;
            4'd2:    w_base = 32'd201805;
            4'd3:    w_base = 32'd213805;
            4'd4:    w_base = 32'd226518;
            4'd5:    w_base = 32'd239988;
            4'd6:    w_base = 32'd254258;
            4'd7:    w_base = 32'd269377;
            4'd8:    w_base = 32'd285395;
            4'd9:    w_base = 32'd302366;
            4'd10:   w_base = 32'd320345;
            4'd11:   w_base = 32'd339394;
            default: w_base = 32'd0;
        endcase
    end

    assign w_inc = w_rest ? 32'd0 : (w_base >> (3'd7 - w_oct));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_enable_q   <= 1'b0;
            r_count      <= '0;
            r_inc        <= '0;
            r_tone       <= 1'b0;
            o_rom_addr   <= '0;
            o_phase_inc  <= '0;
            o_gate       <= 1'b0;
            o_playing    <= 1'b0;
            o_melody_end <= 1'b0;
            o_note_index <= '0;
        end else begin
            r_enable_q   <= i_enable;
            o_melody_end <= 1'b0;
            if (r_state != IDLE && !i_enable) begin
                r_state      <= IDLE;
                r_count      <= '0;
                o_rom_addr   <= '0;
                o_phase_inc  <= '0;
                o_gate       <= 1'b0;
                o_playing    <= 1'b0;
                o_note_index <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_enable && !r_enable_q) begin
                            r_state      <= FETCH;
                            o_rom_addr   <= '0;
                            o_note_index <= '0;
                            o_playing    <= 1'b1;
                        end
                    end
                    FETCH: r_state <= LOAD;
                    LOAD: begin
                        r_count     <= w_load;
                        r_inc       <= w_inc;
                        r_tone      <= !w_rest;
                        o_phase_inc <= w_inc;
                        o_gate      <= !w_rest;
                        r_state     <= PLAY;
                    end
                    PLAY: begin
                        if (r_count == '0) begin
                            o_phase_inc <= '0;
                            o_gate      <= 1'b0;
                            if (o_note_index == LAST_INDEX) begin
                                r_state      <= DONE;
                                o_melody_end <= 1'b1;
                                // playing during DONE doubles as the "loop back" decision
                                o_playing    <= i_loop;
                            end else begin
                                r_state      <= FETCH;
                                o_rom_addr   <= o_note_index + 7'd1;
                                o_note_index <= o_note_index + 7'd1;
                            end
                        end else begin
                            r_count <= w_count_dec;
                            if (w_count_dec < w_gap) begin
                                o_phase_inc <= '0;
                                o_gate      <= 1'b0;
                            end else begin
                                o_phase_inc <= r_inc;
                                o_gate      <= r_tone;
                            end
                        end
                    end
                    DONE: begin
                        r_state      <= o_playing ? FETCH : IDLE;
                        o_rom_addr   <= '0;
                        o_note_index <= '0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of the FM/DDS core. Steps through a melody held in an external note ROM and converts each note code into a 32-bit DDS phase increment.
- Holds each note for its encoded duration in 16th-notes, and reports playing, the melody-end pulse and the current note index.
- Replaces the hard-wired note sequencing so that melodies can be swapped by changing only the ROM.

Parameters:
- CLOCKS_PER_16TH, 6_250_000, clk cycles per 16th-note (120 BPM at 50 MHz).
- MELODY_LENGTH, 82, number of ROM entries played (1..128).
- GAP_CYCLES, 250_000, articulation silence at the end of each note; must be < CLOCKS_PER_16TH.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous reset, active-high.
- enable  input  1  run playback; low aborts.
- loop  input  1  restart at index 0 after the last note.
- rom_addr  output  7  note ROM address.
- rom_data  input  12  ROM word, valid 1 cycle after rom_addr: [11:8] = duration, [6:4] = octave, [3:0] = semitone, [7] = rest.
- phase_inc  output  32  DDS phase increment; 0 means silence.
- gate  output  1  high while a non-rest tone is sounding.
- playing  output  1  high from start of playback until end/abort.
- melody_end  output  1  1-cycle pulse after the last note completes.
- note_index  output  7  index of the note currently sounding.

Behaviour:
- Reset: state IDLE; all outputs 0 (rom_addr, phase_inc, gate, playing, melody_end, note_index); counters cleared.
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE:
  - phase_inc = 0, playing = 0.
  - enable=1 → FETCH with rom_addr = 0, note_index = 0.
- FETCH: rom_addr stable for 1 cycle → LOAD.
- LOAD:
  - Capture rom_data and decode.
  - Duration: dur = rom_data[11:8], where 0 encodes 16. Load note counter with dur*CLOCKS_PER_16TH − 1. Width must hold 16*CLOCKS_PER_16TH.
  - Increment: phase_inc_next = BASE[semitone] >> (7 − octave).
  - BASE = 32-bit rounded octave-7 increments at 50 MHz: round(440·2^((s−9)/12)·8·2^32/50e6), with BASE[9] = 302366. Semitone 12..15 is treated as a rest.
  - Rest bit set → phase_inc_next = 0.
  - → PLAY.
- PLAY:
  - Entered 2 cycles after FETCH entry, i.e. the first tone cycle is 3 clocks after enable is first sampled high in IDLE.
  - phase_inc and gate are driven from the LOAD capture.
  - Counter decrements each cycle.
  - When counter < GAP_CYCLES: phase_inc = 0, gate = 0.
  - Counter = 0 and note_index < MELODY_LENGTH−1 → FETCH next, with rom_addr = note_index+1 and note_index incremented on FETCH entry.
  - Counter = 0 on the last note → DONE.
- FETCH/LOAD: phase_inc = 0, gate = 0 (inter-note silence of 2 cycles).
- DONE: melody_end = 1 for exactly 1 cycle.
  - loop=1 and enable=1 → FETCH at index 0, with playing held 1 throughout.
  - Otherwise → IDLE, playing = 0 in the same cycle melody_end is high.
- playing: 1 in FETCH/LOAD/PLAY, and in DONE when looping.
- Abort: enable=0 in any non-IDLE state → IDLE next cycle. phase_inc, gate, playing, note_index = 0. No melody_end pulse.
- enable held high after a non-loop finish: stay IDLE until enable falls and rises again. Rising-edge detect is on the enable register.
- loop is sampled only in DONE; changes mid-melody take effect at the end.
- Outputs are registered. rom_addr never exceeds MELODY_LENGTH−1.
- Async reset mid-PLAY: outputs go to 0 immediately. Playback restarts at index 0 on the next enable edge after reset release.

Test Plan:
- Reset, then enable↑ with ROM[0] = 0x449 (A4, dur 4) → phase_inc = 37795 from the 3rd clock. gate=1 for 4·CPS−GAP cycles, then 0. rom_addr=1 after 4·CPS cycles.
- ROM[0] = 0x0C9 (dur 0 → 16, octave 4) → note lasts 16·CPS cycles. Octave 7 entry 0x179 → phase_inc = 302366.
- Rest word 0x2C0 → phase_inc = 0 and gate = 0 for the full 2·CPS, while playing=1.
- MELODY_LENGTH=3, loop=0, enable held 1 → indices 0,1,2, one melody_end pulse, playing falls in the same cycle, no restart until enable is toggled.
- loop=1 → melody_end pulse, next rom_addr = 0, playing never drops; 2 full passes verified.
- enable=0 mid-PLAY, then rst pulse mid-note → next cycle all outputs 0, no melody_end. Re-enable restarts at index 0.
